data_memory_pipelined: RTL

Parametrised, handshaked data memory that replaces the fixed 8-bit/128-entry data memory in the processor datapath. It adds:
- configurable data width, address width, depth and read latency;
- per-byte write enables;
- a valid/ready request interface with an in-order, fixed-latency response;
- an out-of-range error flag;
- a hardware zero-fill sequence after reset.

It sits between the execute stage and the writeback mux.

---
 rtl/data_memory_pipelined.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/data_memory_pipelined.sv
// Purpose : parametrised word-addressed data memory with byte enables, zero-filled after reset.
// Latency : fixed RD_LAT cycles from request acceptance to rsp_valid; responses stay in order.
// Backpr. : req_ready is low only during zero-fill; one request per cycle otherwise; no response back-pressure.
//
// Ports:
//   clk, rst            - single clock, synchronous active-high reset
//   req_valid/req_ready - request handshake (req_ready is a pure register output)
//   req_write           - 1 = write, 0 = read
//   req_addr            - word address; bits above log2(DEPTH) only feed the range check
//   req_wdata, req_be   - write data and per-byte write enables (ignored on reads)
//   rsp_valid           - one-cycle response strobe, RD_LAT cycles after acceptance
//   rsp_rdata, rsp_err  - read data (0 for writes/errors), out-of-range flag; both 0 when idle
//   init_busy           - zero-fill in progress
module data_memory_pipelined #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 128,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_busy
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] CLR_LAST  = IDX_W'(DEPTH - 1);
  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    clr_ptr_q, clr_ptr_d;
  logic                init_busy_q, init_busy_d;
  logic                req_ready_q, req_ready_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [IDX_W-1:0]    mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // Response pipeline; stage 0 is loaded at the accepting edge.
  logic                pipe_vld_q [RD_LAT];
  logic                pipe_vld_d [RD_LAT];
  logic                pipe_err_q [RD_LAT];
  logic                pipe_err_d [RD_LAT];
  logic [DATA_W-1:0]   pipe_dat_q [RD_LAT];
  logic [DATA_W-1:0]   pipe_dat_d [RD_LAT];

  logic                accept;
  logic                in_range;
  logic [IDX_W-1:0]    req_idx;
  logic [DATA_W-1:0]   rd_word;

  assign accept   = req_valid & req_ready_q;
  assign in_range = ({1'b0, req_addr} < DEPTH_LIM);
  assign req_idx  = req_addr[IDX_W-1:0];
  // Old array contents: serves both the read data and the unmasked lanes of a write.
  assign rd_word  = mem_q[req_idx];

  // Control and array write port.
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    init_busy_d = init_busy_q;
    req_ready_d = req_ready_q;
    mem_we      = 1'b0;
    mem_waddr   = clr_ptr_q;
    mem_wdata   = '0;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == CLR_LAST) begin
          state_d     = ST_READY;
          init_busy_d = 1'b0;
          req_ready_d = 1'b1;
          clr_ptr_d   = '0;
        end
      end
      ST_READY: begin
        // Out-of-range writes must not touch the array (no aliasing).
        if (accept && req_write && in_range) begin
          mem_we    = 1'b1;
          mem_waddr = req_idx;
          for (int i = 0; i < NB; i++) begin
            mem_wdata[8*i +: 8] = req_be[i] ? req_wdata[8*i +: 8] : rd_word[8*i +: 8];
          end
        end
      end
      default: ;
    endcase
  end

  // Response pipeline next state; invalid slots carry zeros so idle outputs read 0.
  always_comb begin
    for (int i = 0; i < RD_LAT; i++) begin
      pipe_vld_d[i] = 1'b0;
      pipe_err_d[i] = 1'b0;
      pipe_dat_d[i] = '0;
    end
    pipe_vld_d[0] = accept;
    pipe_err_d[0] = accept & ~in_range;
    pipe_dat_d[0] = (accept && !req_write && in_range) ? rd_word : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_err_d[i] = pipe_err_q[i-1];
      pipe_dat_d[i] = pipe_dat_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      clr_ptr_q   <= '0;
      init_busy_q <= 1'b1;
      req_ready_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_err_q[i] <= 1'b0;
        pipe_dat_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      init_busy_q <= init_busy_d;
      req_ready_q <= req_ready_d;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_d[i];
        pipe_err_q[i] <= pipe_err_d[i];
        pipe_dat_q[i] <= pipe_dat_d[i];
      end
    end
  end

  // Array has no reset of its own; the INIT sequence clears it. A reset edge
  // must not commit a write that was in progress.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign req_ready = req_ready_q;
  assign init_busy = init_busy_q;
  assign rsp_valid = pipe_vld_q[RD_LAT-1];
  assign rsp_rdata = pipe_dat_q[RD_LAT-1];
  assign rsp_err   = pipe_err_q[RD_LAT-1];

endmodule
